// File: rtl/bcd_entrada.sv
// bcd_entrada
//   Keypad entry register for three decimal digits, followed by a serial
//   BCD-to-binary conversion using reverse double-dabble.
//
//   State table
//     ENTRADA  | idle; accepts digits, starts conversion on confirma
//     CONVERTE | 12 shift/adjust iterations over {work, acc}
//     FIM      | one cycle; publishes acc on saida and pulses pronto
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous, active-high
//   digito_valido in   strobe: digito is valid this cycle
//   digito        in   keyed digit (0-9 legal)
//   confirma      in   strobe: convert the current entry
//   limpa         in   strobe: clear entry, error flag, abort conversion
//   bcd           out  entry register {hundreds, tens, units}
//   saida         out  binary result of the last completed conversion
//   pronto        out  one-cycle pulse when saida updates
//   ocupado       out  high while converting
//   erro          out  sticky illegal-digit flag
module bcd_entrada (
  input  logic        clk,
  input  logic        reset,
  input  logic        digito_valido,
  input  logic [3:0]  digito,
  input  logic        confirma,
  input  logic        limpa,
  output logic [11:0] bcd,
  output logic [11:0] saida,
  output logic        pronto,
  output logic        ocupado,
  output logic        erro
);

  typedef enum logic [1:0] {
    ENTRADA  = 2'd0,
    CONVERTE = 2'd1,
    FIM      = 2'd2
  } state_t;

  state_t      state;
  logic [11:0] work;
  logic [11:0] acc;
  logic [3:0]  cnt;

  logic [23:0] shifted;
  logic [11:0] work_adj;

  // One reverse double-dabble iteration: shift the pair right, then pull
  // each BCD nibble that now reads >= 8 back into range by subtracting 3.
  always_comb begin
    shifted  = {work, acc} >> 1;
    work_adj = shifted[23:12];
    for (int i = 0; i < 3; i++) begin
      if (shifted[12 + 4*i +: 4] >= 4'd8)
        work_adj[4*i +: 4] = shifted[12 + 4*i +: 4] - 4'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ENTRADA;
      bcd    <= '0;
      saida  <= '0;
      pronto <= 1'b0;
      erro   <= 1'b0;
      work   <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      pronto <= 1'b0;
      if (limpa) begin
        // Abort wins over everything; saida keeps the last good result.
        state <= ENTRADA;
        bcd   <= '0;
        erro  <= 1'b0;
        cnt   <= '0;
      end else begin
        case (state)
          ENTRADA: begin
            if (confirma) begin
              work  <= bcd;
              acc   <= '0;
              cnt   <= '0;
              state <= CONVERTE;
            end else if (digito_valido) begin
              if (digito <= 4'd9)
                bcd <= {bcd[7:0], digito};
              else
                erro <= 1'b1;
            end
          end
          CONVERTE: begin
            work <= work_adj;
            acc  <= shifted[11:0];
            cnt  <= cnt + 4'd1;
            if (cnt == 4'd11)
              state <= FIM;
          end
          FIM: begin
            saida  <= acc;
            pronto <= 1'b1;
            state  <= ENTRADA;
          end
          default: state <= ENTRADA;
        endcase
      end
    end
  end

  assign ocupado = (state == CONVERTE);

endmodule

// File: tb/tb_bcd_entrada.sv
module tb_bcd_entrada;

  logic        clk = 1'b0;
  logic        reset;
  logic        digito_valido;
  logic [3:0]  digito;
  logic        confirma;
  logic        limpa;
  logic [11:0] bcd;
  logic [11:0] saida;
  logic        pronto;
  logic        ocupado;
  logic        erro;

  bcd_entrada dut (
    .clk          (clk),
    .reset        (reset),
    .digito_valido(digito_valido),
    .digito       (digito),
    .confirma     (confirma),
    .limpa        (limpa),
    .bcd          (bcd),
    .saida        (saida),
    .pronto       (pronto),
    .ocupado      (ocupado),
    .erro         (erro)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int val;
    int edge_n;
  } exp_t;

  exp_t sb[$];

  // Reference model: three decimal digits, a sticky error bit, the last
  // published result and the timing window of the conversion in flight.
  int d2, d1, d0;
  bit merr;
  int msaida;
  bit conv_valid;
  int conv_start;

  int tests = 0;
  int fails = 0;

  function automatic int exp_bcd();
    return d2 * 256 + d1 * 16 + d0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic bit conv_busy(input int e);
    return conv_valid && (e <= conv_start + 13);
  endfunction

  task automatic step(input bit dv, input logic [3:0] d, input bit cf, input bit lp);
    int e;
    @(negedge clk);
    digito_valido = dv;
    digito        = d;
    confirma      = cf;
    limpa         = lp;
    e = edge_cnt + 1;
    if (lp) begin
      if (conv_busy(e)) begin
        if (sb.size() > 0) void'(sb.pop_back());
        conv_valid = 1'b0;
      end
      d2 = 0; d1 = 0; d0 = 0;
      merr = 1'b0;
    end else if (!conv_busy(e)) begin
      if (cf) begin
        sb.push_back('{d2 * 100 + d1 * 10 + d0, e + 13});
        conv_valid = 1'b1;
        conv_start = e;
      end else if (dv) begin
        if (d <= 4'd9) begin
          d2 = d1; d1 = d0; d0 = int'(d);
        end else begin
          merr = 1'b1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic key(input logic [3:0] d);
    step(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bcd"},     bcd,     0);
    check({tag, "_saida"},   saida,   0);
    check({tag, "_pronto"},  pronto,  0);
    check({tag, "_ocupado"}, ocupado, 0);
    check({tag, "_erro"},    erro,    0);
  endtask

  task automatic model_clear();
    sb.delete();
    d2 = 0; d1 = 0; d0 = 0;
    merr       = 1'b0;
    msaida     = 0;
    conv_valid = 1'b0;
    conv_start = 0;
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock.
  task automatic reset_mid();
    @(negedge clk);
    digito_valido = 1'b0;
    confirma      = 1'b0;
    limpa         = 1'b0;
    digito        = 4'd0;
    check("pre_reset_ocupado", ocupado, 1);
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset");
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: compares every visible output after each edge and retires
  // scoreboard entries exactly on the cycle pronto is due.
  initial begin
    int  e;
    bit  exp_ocup;
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        e = edge_cnt;
        exp_ocup = conv_valid && (e >= conv_start) && (e <= conv_start + 11);
        check("bcd", bcd, exp_bcd());
        check("erro", erro, merr);
        check("ocupado", ocupado, exp_ocup);
        if (sb.size() > 0 && sb[0].edge_n == e) begin
          x = sb.pop_front();
          check("pronto", pronto, 1);
          check("saida", saida, x.val);
          msaida = x.val;
        end else begin
          check("pronto_idle", pronto, 0);
          check("saida_hold", saida, msaida);
        end
      end
    end
  end

  initial begin
    bit dv, cf, lp;
    int r;
    logic [3:0] d;

    reset         = 1'b1;
    digito_valido = 1'b0;
    digito        = 4'd0;
    confirma      = 1'b0;
    limpa         = 1'b0;
    model_clear();
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 1,2,3 -> 123
    key(4'd1); key(4'd2); key(4'd3);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    idle(15);

    // 9,9,9 -> 999 ; 1,2,3,4 -> 234
    key(4'd9); key(4'd9); key(4'd9);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    idle(15);
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    idle(15);

    // Illegal digit sets sticky erro, conversion still proceeds
    step(1'b0, 4'd0, 1'b0, 1'b1);
    key(4'd5); key(4'hA);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    idle(15);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    idle(2);

    // Empty entry converts to zero
    step(1'b0, 4'd0, 1'b1, 1'b0);
    idle(15);

    // Inputs ignored during conversion; limpa at conversion cycle 6 aborts
    key(4'd1); key(4'd2);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    key(4'd8);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    step(1'b1, 4'd3, 1'b1, 1'b0);
    idle(2);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    idle(16);

    // confirma beats a same-cycle digit
    key(4'd4); key(4'd2);
    step(1'b1, 4'd7, 1'b1, 1'b0);
    idle(15);

    // Reset in the middle of a conversion
    key(4'd5); key(4'd6); key(4'd7);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    idle(5);
    reset_mid();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r  = int'($urandom_range(0, 99));
      dv = (r < 40);
      cf = (r >= 40 && r < 50);
      lp = (r >= 97);
      if ($urandom_range(0, 9) == 0) dv = 1'b1;
      if ($urandom_range(0, 9) == 0)
        d = 4'($urandom_range(10, 15));
      else
        d = 4'($urandom_range(0, 9));
      step(dv, d, cf, lp);
    end
    idle(20);

    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
